alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
Initiator side of the 4-bit ALU opcode interface. Accepts a command (opcode plus A, B) on a valid/ready handshake and drives registered opcode/operand lines into the opcode decoder/ALU. It waits a fixed settle time, captures out/c_out, and returns a response with flags on a second valid/ready handshake. It sits between front-panel or alarm-clock control logic and the decoder-fronted ALU, so no combinational path runs from switches to the ALU.

Parameters:
WIDTH, 4, operand/result width; must match the decoder (4).
SETTLE_CYCLES, 2, clocks from the command-accept edge to the result-capture edge; legal range 1..15. 0 is illegal and is a compile-time error.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  issuer can accept a command
cmd_opcode  in  4  ALU opcode (decoder encoding 0000..1111)
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
alu_opcode  out  4  registered opcode to the decoder
alu_a  out  WIDTH  registered A to the decoder
alu_b  out  WIDTH  registered B to the decoder
alu_out  in  WIDTH  decoder/ALU result
alu_c_out  in  1  decoder/ALU carry out
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_out  out  WIDTH  captured result
rsp_c_out  out  1  captured carry
rsp_zero  out  1  captured result == 0
rsp_opcode  out  4  opcode that produced this response
op_count  out  8  completed-response counter
rsp_err  out  1  present only with ALU_CMD_CHECK_EN

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ready=0; all alu_*, rsp_* outputs, op_count and rsp_err are 0. cmd_ready rises on the first clk edge after rst deasserts.
- FSM has three states:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready at edge T, register cmd_* into alu_*, load settle counter with SETTLE_CYCLES-1, go to SETTLE, and drop cmd_ready.
  - SETTLE: the counter decrements each cycle. At counter==0 (edge T+SETTLE_CYCLES), capture alu_out, alu_c_out, zero flag and opcode into rsp_*, set rsp_valid, and go to RESP.
  - RESP: rsp_* stay stable while rsp_valid&&!rsp_ready. On rsp_valid&&rsp_ready, clear rsp_valid, increment op_count, return to IDLE, and raise cmd_ready.
- Latency is SETTLE_CYCLES clocks from accept to rsp_valid. The minimum command period is SETTLE_CYCLES+1 clocks with rsp_ready tied high.
- cmd_valid outside IDLE is ignored. Callers must hold the command until cmd_ready.
- alu_* hold the last issued command between operations and change only on an accept edge.
- rsp_out/c_out/zero/opcode keep their last values after the handshake. Only rsp_valid clears.
- op_count is 8-bit modulo: 255 -> 0 on the next response handshake.
- Reset mid-SETTLE or mid-RESP aborts immediately. The in-flight result is discarded and op_count is not incremented.

Optional Feature:
Macro ALU_CMD_CHECK_EN.
- With the macro: an internal reference model computes the expected result from alu_opcode/alu_a/alu_b, truncated mod 2^WIDTH:
  - 0000 -A; 0001 -B; 0010 ~A; 0011 ~B
  - 0100 A+B; 0101 A-B; 0110 A+1; 0111 A-1
  - 1000 A*B (low bits); 1001 B-A
  - 1010 AND; 1011 OR; 1100 NAND; 1101 NOR; 1110 XOR; 1111 XNOR
- rsp_err is captured with rsp_out and is 1 when alu_out differs from the expected result. Carry is not checked.
- Without the macro: the rsp_err port and the model are absent, and there is no other behavioural change.

Decomposition:
- Shared package alu_cmd_pkg holds:
  - the 16 opcode localparams (OP_NEG_A=4'b0000 … OP_XNOR=4'b1111)
  - the FSM state encoding (IDLE, SETTLE, RESP)
  - the WIDTH default
- One sub-module, alu_ref_model, is combinational and instantiated only under ALU_CMD_CHECK_EN.

Test Plan:
- After reset release, send opcode 0100, A=7, B=9 with rsp_ready=1 -> rsp_valid exactly 2 clocks after accept; rsp_out=0, rsp_c_out=1, rsp_zero=1; op_count=1.
- Send 0101, A=3, B=5, then 1000, A=3, B=6 back-to-back with cmd_valid held -> second accept exactly 3 clocks after the first; responses are 14 then 2, in order.
- Hold rsp_ready=0 for 5 clocks in RESP while toggling cmd_valid/cmd_a -> rsp_* stable, cmd_ready=0, alu_* unchanged, no extra response.
- Assert rst during SETTLE -> all outputs 0 asynchronously; after release the first response is for the new command only and op_count=1.
- Issue 256 commands (opcode 1010) -> op_count wraps to 0 on the 256th handshake.
- With ALU_CMD_CHECK_EN: force alu_out=4'hF for opcode 0110, A=2 -> rsp_err=1. Release the force and repeat -> rsp_out=3, rsp_err=0.

Source files
------------

// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU command issuer: opcode encodings of the
// decoder-fronted 4-bit ALU, issuer FSM state encoding and the default width.
package alu_cmd_pkg;

    localparam int ALU_WIDTH = 4;

    localparam logic [3:0] OP_NEG_A = 4'b0000;
    localparam logic [3:0] OP_NEG_B = 4'b0001;
    localparam logic [3:0] OP_NOT_A = 4'b0010;
    localparam logic [3:0] OP_NOT_B = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_INC   = 4'b0110;
    localparam logic [3:0] OP_DEC   = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_RSUB  = 4'b1001;
    localparam logic [3:0] OP_AND   = 4'b1010;
    localparam logic [3:0] OP_OR    = 4'b1011;
    localparam logic [3:0] OP_NAND  = 4'b1100;
    localparam logic [3:0] OP_NOR   = 4'b1101;
    localparam logic [3:0] OP_XOR   = 4'b1110;
    localparam logic [3:0] OP_XNOR  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational reference model of the decoder-fronted ALU. Result is
// truncated to WIDTH bits; carry is not modelled. Used by alu_cmd_issuer
// only when ALU_CMD_CHECK_EN is defined.
module alu_ref_model
    import alu_cmd_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] expected
);

    logic [2*WIDTH-1:0] product;

    // Full-width product; only the low WIDTH bits are the ALU result
    assign product = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Expected ALU result for the registered opcode and operands
    always_comb begin
        expected = '0;
        case (opcode)
            OP_NEG_A: expected = -a;
            OP_NEG_B: expected = -b;
            OP_NOT_A: expected = ~a;
            OP_NOT_B: expected = ~b;
            OP_ADD:   expected = a + b;
            OP_SUB:   expected = a - b;
            OP_INC:   expected = a + WIDTH'(1);
            OP_DEC:   expected = a - WIDTH'(1);
            OP_MUL:   expected = product[WIDTH-1:0];
            OP_RSUB:  expected = b - a;
            OP_AND:   expected = a & b;
            OP_OR:    expected = a | b;
            OP_NAND:  expected = ~(a & b);
            OP_NOR:   expected = ~(a | b);
            OP_XOR:   expected = a ^ b;
            OP_XNOR:  expected = ~(a ^ b);
            default:  expected = '0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Initiator for the 4-bit ALU opcode interface. Registers a command onto the
// alu_* lines, waits SETTLE_CYCLES clocks, captures the ALU result and returns
// it with flags as a response. Optional result checking against an internal
// reference model is enabled by defining ALU_CMD_CHECK_EN (adds rsp_err).
module alu_cmd_issuer
    import alu_cmd_pkg::*;
#(
    parameter int WIDTH         = ALU_WIDTH,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_c_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_c_out,
    output logic             rsp_zero,
    output logic [3:0]       rsp_opcode,
    output logic [7:0]       op_count
`ifdef ALU_CMD_CHECK_EN
    ,
    output logic             rsp_err
`endif
);

    // Settle counter is 4 bits wide, so the settle time must fit in 1..15
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("alu_cmd_issuer: SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both high. A valid side holds its payload stable until that
    // edge. cmd_ready is high in IDLE, and also in RESP during the cycle the
    // response is being accepted, so a new command can be taken on the same
    // edge that retires the previous response.
    state_t     state;
    logic [3:0] settle_cnt;
    logic       idle_ready;
    logic       cmd_accept;
    logic       capture_err;

    assign cmd_ready  = idle_ready | (rsp_valid & rsp_ready);
    assign cmd_accept = cmd_valid & cmd_ready;

`ifdef ALU_CMD_CHECK_EN
    logic [WIDTH-1:0] ref_out;

    alu_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref_model (
        .opcode   (alu_opcode),
        .a        (alu_a),
        .b        (alu_b),
        .expected (ref_out)
    );

    assign capture_err = (alu_out != ref_out);
`else
    assign capture_err = 1'b0;
`endif

    // Issuer FSM: command accept, settle countdown, response hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            idle_ready <= 1'b0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_out    <= '0;
            rsp_c_out  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_opcode <= '0;
            op_count   <= '0;
`ifdef ALU_CMD_CHECK_EN
            rsp_err    <= 1'b0;
`endif
        end else begin
            // Accept is only possible in IDLE or on a RESP retire edge
            if (cmd_accept) begin
                alu_opcode <= cmd_opcode;
                alu_a      <= cmd_a;
                alu_b      <= cmd_b;
                settle_cnt <= SETTLE_LOAD;
            end

            case (state)
                IDLE: begin
                    idle_ready <= 1'b1;
                    if (cmd_accept) begin
                        idle_ready <= 1'b0;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        rsp_out    <= alu_out;
                        rsp_c_out  <= alu_c_out;
                        rsp_zero   <= (alu_out == '0);
                        rsp_opcode <= alu_opcode;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
`ifdef ALU_CMD_CHECK_EN
                        rsp_err    <= capture_err;
`endif
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 8'd1;
                        if (cmd_valid) begin
                            state <= SETTLE;
                        end else begin
                            state      <= IDLE;
                            idle_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    idle_ready <= 1'b0;
                end
            endcase
        end
    end

    logic unused_err;
    assign unused_err = capture_err;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural ALU stand-in and an
// expected-response queue. Define ALU_CMD_CHECK_EN to exercise rsp_err.
module tb_alu_cmd_issuer;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int EW = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_opcode;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_out;
    logic         alu_c_out;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_out;
    logic         rsp_c_out;
    logic         rsp_zero;
    logic [3:0]   rsp_opcode;
    logic [7:0]   op_count;
`ifdef ALU_CMD_CHECK_EN
    logic         rsp_err;
`endif

    alu_cmd_issuer #(
        .WIDTH         (W),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_c_out  (alu_c_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_out    (rsp_out),
        .rsp_c_out  (rsp_c_out),
        .rsp_zero   (rsp_zero),
        .rsp_opcode (rsp_opcode),
        .op_count   (op_count)
`ifdef ALU_CMD_CHECK_EN
        ,
        .rsp_err    (rsp_err)
`endif
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    int neg_cnt = 0;
    always @(negedge clk) neg_cnt <= neg_cnt + 1;

    // ---------------- behavioural ALU stand-in ----------------
    logic         force_en = 1'b0;
    logic [W-1:0] force_val = '0;

    function automatic logic [4:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] ea;
        logic [4:0] eb;
        logic [7:0] p;
        logic [4:0] r;
        ea = {1'b0, a};
        eb = {1'b0, b};
        p  = {4'b0, a} * {4'b0, b};
        case (op)
            4'h0: r = 5'd0 - ea;
            4'h1: r = 5'd0 - eb;
            4'h2: r = {1'b0, ~a};
            4'h3: r = {1'b0, ~b};
            4'h4: r = ea + eb;
            4'h5: r = ea - eb;
            4'h6: r = ea + 5'd1;
            4'h7: r = ea - 5'd1;
            4'h8: r = p[4:0];
            4'h9: r = eb - ea;
            4'hA: r = {1'b0, a & b};
            4'hB: r = {1'b0, a | b};
            4'hC: r = {1'b0, ~(a & b)};
            4'hD: r = {1'b0, ~(a | b)};
            4'hE: r = {1'b0, a ^ b};
            default: r = {1'b0, ~(a ^ b)};
        endcase
        return r;
    endfunction

    logic [4:0] alu_r;
    always_comb begin
        alu_r     = alu_fn(alu_opcode, alu_a, alu_b);
        alu_out   = force_en ? force_val : alu_r[3:0];
        alu_c_out = alu_r[4];
    end

    // Expected response word {opcode, zero, c_out, out}
    function automatic logic [EW-1:0] exp_of(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        logic [3:0] o;
        r = alu_fn(op, a, b);
        o = force_en ? force_val : r[3:0];
        return {op, (o == 4'h0), r[4], o};
    endfunction

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [W-1:0]  got_log[$];

    always @(negedge clk) begin
        #1;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_rsp", 32'(rsp_opcode), 32'hFFFF_FFFF);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                chk("rsp_fields", 32'({rsp_opcode, rsp_zero, rsp_c_out, rsp_out}), 32'(e));
            end
            got_log.push_back(rsp_out);
        end
    end

    // ---------------- driver tasks ----------------
    // Called aligned to a falling edge; returns aligned to the falling edge after accept
    task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        for (int i = 0; i < 40 && !got; i++) begin
            #2;
            if (cmd_ready) begin
                exp_q.push_back(exp_of(op, a, b));
                acc = neg_cnt;
                got = 1'b1;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Returns 2 time units after the falling edge where rsp_valid is first seen
    task automatic wait_rsp(output int m);
        bit got;
        got = 1'b0;
        m = -1;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (rsp_valid) begin
                m = neg_cnt;
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    // Returns aligned to the falling edge after the last outstanding handshake
    task automatic wait_drain();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 80; i++) begin
            #2;
            if (exp_q.size() == 0) got = 1'b1;
            @(negedge clk);
            if (got) break;
        end
        if (!got) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int acc;
        int acc2;
        int m;
        int sz;

        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_ready", 32'(cmd_ready), 32'd0);
        chk("reset_rsp", 32'({rsp_valid, rsp_opcode, rsp_zero, rsp_c_out, rsp_out}), 32'd0);
        chk("reset_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        chk("reset_count", 32'(op_count), 32'd0);
`ifdef ALU_CMD_CHECK_EN
        chk("reset_err", 32'(rsp_err), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #2 chk("ready_before_edge", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        #2 chk("ready_after_edge", 32'(cmd_ready), 32'd1);
        @(negedge clk);

        // 7 + 9 wraps to 0 with carry; latency from accept to rsp_valid
        rsp_ready = 1'b1;
        send(4'b0100, 4'd7, 4'd9, acc);
        wait_rsp(m);
        chk("latency", 32'(m - 1 - acc), 32'(S));
        chk("add_out", 32'(rsp_out), 32'd0);
        chk("add_carry", 32'(rsp_c_out), 32'd1);
        chk("add_zero", 32'(rsp_zero), 32'd1);
        @(negedge clk);
        #2 chk("count_1", 32'(op_count), 32'd1);
        @(negedge clk);

        // Back-to-back with cmd_valid held: period S+1, responses in order
        sz = got_log.size();
        send(4'b0101, 4'd3, 4'd5, acc);
        send(4'b1000, 4'd3, 4'd6, acc2);
        chk("b2b_period", 32'(acc2 - acc), 32'(S + 1));
        wait_drain();
        chk("b2b_rsp_count", 32'(got_log.size()), 32'(sz + 2));
        if (got_log.size() >= sz + 2) begin
            chk("b2b_first", 32'(got_log[sz]), 32'd14);
            chk("b2b_second", 32'(got_log[sz + 1]), 32'd2);
        end
        #2 chk("count_3", 32'(op_count), 32'd3);
        @(negedge clk);

        // Back-pressure: response held while command inputs churn
        rsp_ready = 1'b0;
        sz = got_log.size();
        send(4'b0010, 4'd5, 4'd0, acc);
        wait_rsp(m);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_a      = 4'($urandom_range(0, 15));
            cmd_opcode = 4'($urandom_range(0, 15));
            #2;
            chk("hold_ready", 32'(cmd_ready), 32'd0);
            chk("hold_rsp", 32'({rsp_valid, rsp_opcode, rsp_zero, rsp_c_out, rsp_out}), 32'({1'b1, 4'h2, 1'b0, 1'b0, 4'hA}));
            chk("hold_alu", 32'({alu_opcode, alu_a, alu_b}), 32'({4'h2, 4'h5, 4'h0}));
            @(negedge clk);
        end
        chk("hold_no_extra", 32'(got_log.size()), 32'(sz));
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain();
        chk("hold_one_rsp", 32'(got_log.size()), 32'(sz + 1));
        #2 chk("count_4", 32'(op_count), 32'd4);
        @(negedge clk);

        // Reset mid-SETTLE discards the in-flight command
        send(4'b0100, 4'd1, 4'd1, acc);
        #2 rst = 1'b1;
        #1;
        chk("abort_ready", 32'(cmd_ready), 32'd0);
        chk("abort_rsp", 32'({rsp_valid, rsp_opcode, rsp_zero, rsp_c_out, rsp_out}), 32'd0);
        chk("abort_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        chk("abort_count", 32'(op_count), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sz = got_log.size();
        send(4'b1011, 4'hC, 4'h3, acc);
        wait_drain();
        chk("abort_rsp_count", 32'(got_log.size()), 32'(sz + 1));
        if (got_log.size() > sz) chk("abort_new_out", 32'(got_log[sz]), 32'hF);
        #2 chk("abort_count_1", 32'(op_count), 32'd1);
        @(negedge clk);

        // Mixed opcodes back-to-back, checked by the scoreboard
        for (int i = 0; i < 12; i++) begin
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), acc);
        end
        wait_drain();
        #2 chk("count_13", 32'(op_count), 32'd13);
        @(negedge clk);

        // op_count wraps after 256 handshakes from reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            send(4'b1010, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), acc);
            wait_drain();
            if (i == 254) begin
                #2 chk("count_255", 32'(op_count), 32'd255);
                @(negedge clk);
            end
        end
        #2 chk("count_wrap", 32'(op_count), 32'd0);
        @(negedge clk);

`ifdef ALU_CMD_CHECK_EN
        // Corrupted ALU result is flagged; clean repeat is not
        force_en  = 1'b1;
        force_val = 4'hF;
        send(4'b0110, 4'd2, 4'd0, acc);
        wait_rsp(m);
        chk("err_forced_out", 32'(rsp_out), 32'hF);
        chk("err_forced_flag", 32'(rsp_err), 32'd1);
        @(negedge clk);
        force_en = 1'b0;
        wait_drain();
        send(4'b0110, 4'd2, 4'd0, acc);
        wait_rsp(m);
        chk("err_clean_out", 32'(rsp_out), 32'd3);
        chk("err_clean_flag", 32'(rsp_err), 32'd0);
        @(negedge clk);
        wait_drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
